piso_shifter: RTL and testbench



---
 rtl/piso_shifter.sv | 73 +++++++
 tb/tb_piso_shifter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/piso_shifter.sv
// piso_shifter: parametrised parallel-in serial-out shifter with load handshake, stall and frame flags (optional sign fill: PISO_SIGN_FILL_EN)
module piso_shifter #(
    parameter int WIDTH = 64,
    parameter int LEN   = 64,
    parameter int CW    = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             msb_first,
    input  logic             shift_en,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic             busy
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q;
    logic             order_q, fill, emit, last, accept;
`ifdef PISO_SIGN_FILL_EN
    logic             sign_q;
    assign fill = sign_q;
`else
    assign fill = 1'b0;
`endif
    assign busy     = state_q == SHIFT;
    assign last     = busy & shift_en & (cnt_q == CW'(LEN - 1));
    assign ld_ready = ~busy | last;
    assign accept   = ld_valid & ld_ready;
    assign emit     = order_q ? shreg_q[WIDTH-1] : shreg_q[0];
    // shift away from the emitting end, fill entering at the opposite end
    always_comb shreg_d = order_q ? {shreg_q[WIDTH-2:0], fill} : {fill, shreg_q[WIDTH-1:1]};
    // frame FSM; a load on the last-bit edge overrides the return to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            order_q   <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef PISO_SIGN_FILL_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            if (busy && shift_en) begin
                out       <= emit;
                out_valid <= 1'b1;
                done      <= last;
                shreg_q   <= shreg_d;
                cnt_q     <= cnt_q + CW'(1);
                if (last) state_q <= IDLE;
            end else begin
                out_valid <= 1'b0;
                done      <= 1'b0;
            end
            if (accept) begin
                shreg_q <= x;
                order_q <= msb_first;
                cnt_q   <= '0;
                state_q <= SHIFT;
`ifdef PISO_SIGN_FILL_EN
                sign_q  <= x[WIDTH-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: directed self-checking bench for piso_shifter (8/8 and 8/12 instances)
module tb_piso_shifter;
    logic clk = 0, rst = 1;
    logic [7:0] x = '0;
    logic ld_valid = 0, ld_valid2 = 0, msb_first = 0, shift_en = 1;
    logic ld_ready, out, out_valid, done, busy;
    logic ld_ready2, out2, out_valid2, done2, busy2;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(8), .LEN(8)) dut (
        .clk(clk), .rst(rst), .x(x), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .msb_first(msb_first), .shift_en(shift_en), .out(out),
        .out_valid(out_valid), .done(done), .busy(busy)
    );

    piso_shifter #(.WIDTH(8), .LEN(12)) dut12 (
        .clk(clk), .rst(rst), .x(x), .ld_valid(ld_valid2), .ld_ready(ld_ready2),
        .msb_first(msb_first), .shift_en(shift_en), .out(out2),
        .out_valid(out_valid2), .done(done2), .busy(busy2)
    );

    task automatic load(input logic [7:0] v, input logic m);
        x = v; msb_first = m; ld_valid = 1;
        @(posedge clk); #1;
        ld_valid = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out, out_valid, done, busy, ld_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset8 got=%b exp=00001", {out, out_valid, done, busy, ld_ready});
        end
        checks++;
        if ({out2, out_valid2, done2, busy2, ld_ready2} !== 5'b00001) begin
            failures++;
            $display("FAIL reset12 got=%b exp=00001", {out2, out_valid2, done2, busy2, ld_ready2});
        end
        #1 rst = 0;
    endtask

    task automatic test_order(input logic m, input logic [7:0] seq);
        load(8'h1F, m);
        checks++;
        if ({busy, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL load_state m=%0b got=%b exp=10", m, {busy, out_valid});
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out, out_valid, done} !== {seq[7-i], 1'b1, i == 7}) begin
                failures++;
                $display("FAIL order m=%0b bit%0d got=%b exp=%b", m, i, {out, out_valid, done}, {seq[7-i], 1'b1, i == 7});
            end
        end
        checks++;
        if ({busy, ld_ready} !== 2'b01) begin
            failures++;
            $display("FAIL order_end m=%0b got=%b exp=01", m, {busy, ld_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle m=%0b got=%b exp=00", m, {out_valid, done});
        end
    endtask

    task automatic test_fill();
        logic [11:0] seq;
`ifdef PISO_SIGN_FILL_EN
        seq = 12'b000000011111;
`else
        seq = 12'b000000010000;
`endif
        x = 8'h80; msb_first = 0; ld_valid2 = 1;
        @(posedge clk); #1;
        ld_valid2 = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out2, out_valid2, done2} !== {seq[11-i], 1'b1, i == 11}) begin
                failures++;
                $display("FAIL fill bit%0d got=%b exp=%b", i, {out2, out_valid2, done2}, {seq[11-i], 1'b1, i == 11});
            end
        end
        checks++;
        if (busy2 !== 1'b0) begin
            failures++;
            $display("FAIL fill_end busy got=%b exp=0", busy2);
        end
    endtask

    task automatic test_back_to_back();
        x = 8'hFF; msb_first = 0; ld_valid = 1;
        @(posedge clk); #1;
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                checks++;
                if (ld_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready got=%b exp=1", ld_ready);
                end
            end
            @(posedge clk); #1;
            if (i == 7) ld_valid = 0;
            checks++;
            if ({out, out_valid, done} !== {i < 8, 1'b1, i == 7 || i == 15}) begin
                failures++;
                $display("FAIL b2b cyc%0d got=%b exp=%b", i, {out, out_valid, done}, {i < 8, 1'b1, i == 7 || i == 15});
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_stall();
        logic [7:0] seq;
        seq = 8'b11111000;
        load(8'h1F, 0);
        for (int i = 0; i < 11; i++) begin
            int b;
            if (i == 3) shift_en = 0;
            if (i == 6) shift_en = 1;
            b = i < 3 ? i : i - 3;
            @(posedge clk); #1;
            checks++;
            if (i >= 3 && i < 6) begin
                if ({out, out_valid, done, busy} !== 4'b1001) begin
                    failures++;
                    $display("FAIL stall cyc%0d got=%b exp=1001", i, {out, out_valid, done, busy});
                end
            end else if ({out, out_valid, done} !== {seq[7-b], 1'b1, i == 10}) begin
                failures++;
                $display("FAIL stall cyc%0d got=%b exp=%b", i, {out, out_valid, done}, {seq[7-b], 1'b1, i == 10});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq;
        seq = 8'b10000000;
        load(8'h1F, 0);
        repeat (4) @(posedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if ({out, out_valid, done, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid got=%b exp=0000", {out, out_valid, done, busy});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, done} !== 2'b00) begin
            failures++;
            $display("FAIL rst_hold got=%b exp=00", {out_valid, done});
        end
        rst = 0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=1", ld_ready);
        end
        load(8'h01, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out, out_valid, done} !== {seq[7-i], 1'b1, i == 7}) begin
                failures++;
                $display("FAIL rst_reload bit%0d got=%b exp=%b", i, {out, out_valid, done}, {seq[7-i], 1'b1, i == 7});
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_order(0, 8'b11111000);
        test_order(1, 8'b00011111);
        test_fill();
        test_back_to_back();
        @(posedge clk); #1;
        test_stall();
        @(posedge clk); #1;
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
